elevator_scan_controller: RTL and testbench
===========================================

// Module: elevator_scan_controller
// PURPOSE
//  Parametrised multi-floor elevator controller. Successor to the fixed 4-bit single-request controller.
//  Latches any number of floor calls into a pending bitmask and serves them in SCAN (collective) order.
//  Sequences motion, door dwell, overweight hold and the door-held-open alarm.
//  Sits between the call-button/sensor front end and the motor/door drive logic.
// PARAMETERS
//  NUM_FLOORS         16   number of floors, 2..64
//  FLOOR_W            4    floor index width; must be >= $clog2(NUM_FLOORS)
//  DWELL_CYCLES       8    cycles the door is commanded open at a stop
//  DOOR_ALERT_CYCLES  180  consecutive door_open cycles before door_alert (3 min at 1 Hz clock)
//  TIMER_W            8    timer width; must hold DOOR_ALERT_CYCLES
// PORTS
//  clock          in   1           system clock, rising edge
//  reset          in   1           asynchronous, active-low (0 = reset)
//  req_valid      in   1           call strobe, sampled each cycle
//  req_floor      in   FLOOR_W     requested floor; values >= NUM_FLOORS are dropped
//  floor_sensor   in   1           one-cycle pulse per floor boundary crossed
//  door_open      in   1           door-position sensor, 1 = physically open
//  over_weight    in   1           load-cell threshold exceeded
//  current_floor  out  FLOOR_W     registered floor index
//  direction      out  1           1 = up, 0 = down
//  moving         out  1           motor enable
//  door_cmd       out  1           door-open command
//  arrived        out  1           one-cycle pulse when a stop is served
//  pending        out  NUM_FLOORS  outstanding-call bitmask
//  door_alert     out  1           door open >= DOOR_ALERT_CYCLES
//  weight_alert   out  1           registered copy of over_weight while door_cmd = 1
// BEHAVIOUR
//  Reset values:
//   - all outputs 0 except direction = 1; state IDLE; timers 0.
//   - Reset mid-motion discards all pending calls.
//  Request capture:
//   - valid req_floor sets pending bit at the next edge (visible 1 cycle later).
//   - Request for current_floor while IDLE or DOOR_OPEN does not set a bit. It opens the door
//     (IDLE) or restarts dwell (DOOR_OPEN).
//   - Same-cycle set and clear of one bit: clear wins.
//  FSM states IDLE, MOVING, DOOR_OPEN:
//   - IDLE, pending nonzero: keep direction if any call lies ahead, else reverse; -> MOVING.
//   - MOVING, floor_sensor: current_floor +/-1, saturating at 0 and NUM_FLOORS-1.
//     If the new floor is pending: clear bit, arrived = 1, moving = 0, -> DOOR_OPEN (same edge).
//     If no call remains ahead: stop at that floor, -> IDLE.
//   - DOOR_OPEN: door_cmd = 1; dwell counts 0..DWELL_CYCLES-1.
//     At expiry, door_open = 0 and over_weight = 0 -> IDLE; otherwise hold until both are 0.
//  Ignored and alarm conditions:
//   - floor_sensor outside MOVING is ignored.
//   - over_weight never stops a car already moving; it only blocks departure.
//   - door_alert: consecutive-door_open counter in every state, saturating at DOOR_ALERT_CYCLES.
//     door_alert = 1 at saturation; counter and alert clear on the first edge with door_open = 0.
//   - weight_alert = 0 whenever door_cmd = 0.
// STRUCTURE
//  Package elevator_pkg:
//   - state enum (IDLE, MOVING, DOOR_OPEN), DIR_UP = 1'b1, DIR_DOWN = 1'b0.
//   - function any_above(mask, floor); function any_below(mask, floor).
//  One sub-module elevator_req_queue:
//   - owns the pending register, set/clear arbitration and range check.
//   - outputs call_here, call_above, call_below.
// TESTING
//  1. reset low 2 cycles, release; req 5 at floor 0; 5 sensor pulses -> moving, dir 1;
//     floor 5 arrived pulse; door_cmd 8 cycles; pending = 0.
//  2. Calls 3, 7, 1 at floor 0 -> stops 3, 7 in order, reverses, stops 1; arrived exactly 3 times.
//  3. over_weight = 1 through dwell expiry -> door_cmd and weight_alert held;
//     drop over_weight -> IDLE next edge.
//  4. door_open high 180 cycles -> door_alert on cycle 180, not 179; door_open low -> alert clears next edge.
//  5. req_floor 15 with NUM_FLOORS = 12 -> pending unchanged;
//     sensor pulse while IDLE -> floor unchanged; set+clear same floor -> bit 0.
//  6. reset asserted while MOVING at floor 4 -> async: floor 0, pending 0, moving 0 before next edge.

Source files
------------

// File: rtl/elevator_pkg.sv
// elevator_pkg: shared state encoding, direction constants and call-mask helpers
// used by the SCAN elevator controller and its request queue.
package elevator_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MOVING,
        DOOR_OPEN
    } state_t;

    localparam logic DIR_UP     = 1'b1;
    localparam logic DIR_DOWN   = 1'b0;
    localparam int   MAX_FLOORS = 64;

    // Masks arrive zero-extended to MAX_FLOORS bits so one helper serves every floor count.
    function automatic logic any_above(input logic [MAX_FLOORS-1:0] mask, input int unsigned flr);
        return |(mask >> (flr + 1));
    endfunction

    function automatic logic any_below(input logic [MAX_FLOORS-1:0] mask, input int unsigned flr);
        logic [MAX_FLOORS-1:0] below;
        below = ({{(MAX_FLOORS-1){1'b0}}, 1'b1} << flr) - {{(MAX_FLOORS-1){1'b0}}, 1'b1};
        return |(mask & below);
    endfunction

endpackage

// File: rtl/elevator_req_queue.sv
// elevator_req_queue: outstanding-call bitmask with range check, set/clear arbitration
// and call-position flags relative to a reference floor.
module elevator_req_queue
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = 16,
    parameter int FLOOR_W    = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_req_valid,
    input  logic [FLOOR_W-1:0]    i_req_floor,
    input  logic                  i_block_en,
    input  logic [FLOOR_W-1:0]    i_block_floor,
    input  logic                  i_clr_valid,
    input  logic [FLOOR_W-1:0]    i_clr_floor,
    input  logic [FLOOR_W-1:0]    i_ref_floor,
    output logic [NUM_FLOORS-1:0] o_pending,
    output logic                  o_call_here,
    output logic                  o_call_above,
    output logic                  o_call_below
);

    localparam logic [FLOOR_W:0]      LP_NUM = (FLOOR_W + 1)'(NUM_FLOORS);
    localparam logic [NUM_FLOORS-1:0] LP_ONE = {{(NUM_FLOORS-1){1'b0}}, 1'b1};

    logic [NUM_FLOORS-1:0] r_pending;
    logic                  w_set;
    logic [NUM_FLOORS-1:0] w_set_mask;
    logic [NUM_FLOORS-1:0] w_clr_mask;
    logic [NUM_FLOORS-1:0] w_ref_mask;
    logic [MAX_FLOORS-1:0] w_pending_ext;

    assign w_set = i_req_valid && ({1'b0, i_req_floor} < LP_NUM)
                && !(i_block_en && (i_req_floor == i_block_floor));

    assign w_set_mask = w_set       ? (LP_ONE << i_req_floor) : '0;
    assign w_clr_mask = i_clr_valid ? (LP_ONE << i_clr_floor) : '0;
    assign w_ref_mask = LP_ONE << i_ref_floor;

    // Clear is applied after set so a call landing on its own serving edge is absorbed.
    // NOTE: non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending | w_set_mask) & ~w_clr_mask;
        end
    end

    assign w_pending_ext = MAX_FLOORS'(r_pending);
    assign o_pending     = r_pending;
    assign o_call_here   = |(r_pending & w_ref_mask);
    assign o_call_above  = any_above(w_pending_ext, 32'(i_ref_floor));
    assign o_call_below  = any_below(w_pending_ext, 32'(i_ref_floor));

endmodule

// File: rtl/elevator_scan_controller.sv
// elevator_scan_controller: SCAN-order elevator sequencer driving motor, door and alarms
// from latched floor calls, the floor-boundary sensor and door/load sensors.
module elevator_scan_controller
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS        = 16,
    parameter int FLOOR_W           = 4,
    parameter int DWELL_CYCLES      = 8,
    parameter int DOOR_ALERT_CYCLES = 180,
    parameter int TIMER_W           = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_req_valid,
    input  logic [FLOOR_W-1:0]    i_req_floor,
    input  logic                  i_floor_sensor,
    input  logic                  i_door_open,
    input  logic                  i_over_weight,
    output logic [FLOOR_W-1:0]    o_current_floor,
    output logic                  o_direction,
    output logic                  o_moving,
    output logic                  o_door_cmd,
    output logic                  o_arrived,
    output logic [NUM_FLOORS-1:0] o_pending,
    output logic                  o_door_alert,
    output logic                  o_weight_alert
);

    localparam logic [FLOOR_W-1:0] LP_TOP_FLOOR  = FLOOR_W'(NUM_FLOORS - 1);
    localparam logic [FLOOR_W-1:0] LP_FLOOR_ONE  = FLOOR_W'(1);
    localparam logic [TIMER_W-1:0] LP_DWELL_LAST = TIMER_W'(DWELL_CYCLES - 1);
    localparam logic [TIMER_W-1:0] LP_ALERT      = TIMER_W'(DOOR_ALERT_CYCLES);
    localparam logic [TIMER_W-1:0] LP_TICK       = TIMER_W'(1);

    state_t             r_state, w_state_nxt;
    logic [FLOOR_W-1:0] r_current_floor, w_floor_nxt, w_step_floor, w_ref_floor;
    logic               r_direction, w_dir_nxt;
    logic [TIMER_W-1:0] r_dwell, w_dwell_nxt;
    logic [TIMER_W-1:0] r_door_cnt;
    logic               r_arrived, w_arrived_nxt;
    logic               r_over_weight;
    logic               w_step, w_req_here, w_clr_valid;
    logic               w_call_here, w_call_above, w_call_below, w_call_ahead;

    assign w_step     = (r_state == MOVING) && i_floor_sensor;
    assign w_req_here = i_req_valid && (i_req_floor == r_current_floor);

    always_comb begin
        w_step_floor = r_current_floor;
        if (r_direction == DIR_UP) begin
            if (r_current_floor != LP_TOP_FLOOR) w_step_floor = r_current_floor + LP_FLOOR_ONE;
        end else begin
            if (r_current_floor != '0) w_step_floor = r_current_floor - LP_FLOOR_ONE;
        end
    end

    // Call flags are judged from the floor the car will occupy after this edge.
    assign w_ref_floor  = w_step ? w_step_floor : r_current_floor;
    assign w_call_ahead = (r_direction == DIR_UP) ? w_call_above : w_call_below;

    elevator_req_queue #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W)
    ) u_req_queue (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_req_valid   (i_req_valid),
        .i_req_floor   (i_req_floor),
        .i_block_en    (r_state != MOVING),
        .i_block_floor (r_current_floor),
        .i_clr_valid   (w_clr_valid),
        .i_clr_floor   (w_step_floor),
        .i_ref_floor   (w_ref_floor),
        .o_pending     (o_pending),
        .o_call_here   (w_call_here),
        .o_call_above  (w_call_above),
        .o_call_below  (w_call_below)
    );

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt   = r_state;
        w_floor_nxt   = r_current_floor;
        w_dir_nxt     = r_direction;
        w_dwell_nxt   = r_dwell;
        w_arrived_nxt = 1'b0;
        w_clr_valid   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_req_here) begin
                    w_state_nxt = DOOR_OPEN;
                    w_dwell_nxt = '0;
                end else if ((|o_pending) && !i_over_weight) begin
                    w_state_nxt = MOVING;
                    if (!w_call_ahead) w_dir_nxt = ~r_direction;
                end
            end
            MOVING: begin
                if (w_step) begin
                    w_floor_nxt = w_step_floor;
                    if (w_call_here) begin
                        w_clr_valid   = 1'b1;
                        w_arrived_nxt = 1'b1;
                        w_state_nxt   = DOOR_OPEN;
                        w_dwell_nxt   = '0;
                    end else if (!w_call_ahead) begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            DOOR_OPEN: begin
                if (w_req_here) begin
                    w_dwell_nxt = '0;
                end else if (r_dwell != LP_DWELL_LAST) begin
                    w_dwell_nxt = r_dwell + LP_TICK;
                end else if (!i_door_open && !i_over_weight) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state         <= IDLE;
            r_current_floor <= '0;
            r_direction     <= DIR_UP;
            r_dwell         <= '0;
            r_arrived       <= 1'b0;
            r_over_weight   <= 1'b0;
            r_door_cnt      <= '0;
        end else begin
            r_state         <= w_state_nxt;
            r_current_floor <= w_floor_nxt;
            r_direction     <= w_dir_nxt;
            r_dwell         <= w_dwell_nxt;
            r_arrived       <= w_arrived_nxt;
            r_over_weight   <= i_over_weight;
            if (!i_door_open) begin
                r_door_cnt <= '0;
            end else if (r_door_cnt != LP_ALERT) begin
                r_door_cnt <= r_door_cnt + LP_TICK;
            end
        end
    end

    assign o_current_floor = r_current_floor;
    assign o_direction     = r_direction;
    assign o_moving        = (r_state == MOVING);
    assign o_door_cmd      = (r_state == DOOR_OPEN);
    assign o_arrived       = r_arrived;
    assign o_door_alert    = (r_door_cnt == LP_ALERT);
    assign o_weight_alert  = o_door_cmd && r_over_weight;

endmodule

// File: tb/tb_elevator_scan_controller.sv
// tb_elevator_scan_controller: directed scenarios plus randomized call batches; served
// stops are predicted by a SCAN sweep model and checked by an independent arrival monitor.
module tb_elevator_scan_controller;

    localparam int NF = 12;
    localparam int FW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic [FW-1:0] req_floor = '0;
    logic          floor_sensor = 1'b0;
    logic          door_open = 1'b0;
    logic          over_weight = 1'b0;
    logic [FW-1:0] cur_floor;
    logic          direction, moving, door_cmd, arrived, door_alert, weight_alert;
    logic [NF-1:0] pending;

    int checks = 0;
    int failures = 0;
    int arrivals = 0;
    int exp_q[$];
    int m_floor;
    logic m_dir;

    elevator_scan_controller #(
        .NUM_FLOORS (NF), .FLOOR_W (FW), .DWELL_CYCLES (8),
        .DOOR_ALERT_CYCLES (180), .TIMER_W (8)
    ) dut (
        .i_clk (clk), .i_rst_n (rst_n), .i_req_valid (req_valid), .i_req_floor (req_floor),
        .i_floor_sensor (floor_sensor), .i_door_open (door_open), .i_over_weight (over_weight),
        .o_current_floor (cur_floor), .o_direction (direction), .o_moving (moving),
        .o_door_cmd (door_cmd), .o_arrived (arrived), .o_pending (pending),
        .o_door_alert (door_alert), .o_weight_alert (weight_alert)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send_req(input logic [FW-1:0] f);
        req_valid = 1'b1;
        req_floor = f;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic pulse();
        floor_sensor = 1'b1;
        tick();
        floor_sensor = 1'b0;
    endtask

    // Feeds random sensor pulses while the car moves until it rests with no calls left.
    task automatic run_car(input int budget);
        int n = 0;
        int quiet = 0;
        while (quiet < 3 && n < budget) begin
            floor_sensor = moving && ($urandom_range(0, 2) == 0);
            tick();
            floor_sensor = 1'b0;
            n++;
            if (!moving && !door_cmd && pending == '0) quiet++;
            else quiet = 0;
        end
        check("run_settled", 64'(quiet >= 3), 64'd1);
    endtask

    // SCAN model: sweep ahead in the current direction, then sweep back through the rest.
    task automatic plan_batch(input logic [NF-1:0] mask);
        int up[$];
        int dn[$];
        int first[$];
        int second[$];
        for (int f = m_floor + 1; f < NF; f++) if (mask[f]) up.push_back(f);
        for (int f = m_floor - 1; f >= 0; f--) if (mask[f]) dn.push_back(f);
        if (m_dir) begin first = up; second = dn; end
        else       begin first = dn; second = up; end
        if (first.size() == 0) begin
            m_dir = ~m_dir;
            first = second;
            second.delete();
        end
        foreach (first[i]) exp_q.push_back(first[i]);
        m_floor = first[first.size() - 1];
        if (second.size() != 0) begin
            m_dir = ~m_dir;
            foreach (second[i]) exp_q.push_back(second[i]);
            m_floor = second[second.size() - 1];
        end
    endtask

    initial begin : monitor
        int exp_f;
        forever begin
            @(negedge clk);
            if (arrived === 1'b1) begin
                arrivals++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL stop_unexpected actual=%0d expected=none at %0t", cur_floor, $time);
                end else begin
                    exp_f = exp_q.pop_front();
                    check("stop_floor", 64'(cur_floor), 64'(exp_f));
                end
            end
        end
    end

    initial begin : stimulus
        int cnt;
        int a0;
        logic [NF-1:0] mask;
        logic [FW-1:0] f;

        // Reset state
        tick(); tick();
        check("rst_floor", 64'(cur_floor), 64'd0);
        check("rst_dir", 64'(direction), 64'd1);
        check("rst_moving", 64'(moving), 64'd0);
        check("rst_door", 64'(door_cmd), 64'd0);
        check("rst_pending", 64'(pending), 64'd0);
        check("rst_alerts", 64'({arrived, door_alert, weight_alert}), 64'd0);
        rst_n = 1'b1;

        // Single call to floor 5 from floor 0
        exp_q.push_back(5);
        send_req(4'd5);
        check("t1_pending", 64'(pending), 64'h020);
        tick();
        check("t1_moving", 64'({moving, direction}), 64'b11);
        for (int i = 1; i <= 5; i++) begin
            pulse();
            check("t1_floor", 64'(cur_floor), 64'(i));
        end
        check("t1_arrived", 64'({arrived, door_cmd, moving}), 64'b110);
        cnt = 0;
        while (door_cmd && cnt < 20) begin cnt++; tick(); end
        check("t1_dwell", 64'(cnt), 64'd8);
        check("t1_pending_clr", 64'(pending), 64'd0);

        // Back to floor 0, then calls 3,7 with 1 added after the car passes it
        exp_q.push_back(0);
        send_req(4'd0);
        run_car(400);
        a0 = arrivals;
        exp_q.push_back(3); exp_q.push_back(7); exp_q.push_back(1);
        send_req(4'd3);
        send_req(4'd7);
        check("t2_dir_up", 64'({moving, direction}), 64'b11);
        pulse(); pulse();
        send_req(4'd1);
        run_car(600);
        check("t2_arrivals", 64'(arrivals - a0), 64'd3);
        check("t2_end", 64'({cur_floor, direction}), 64'({4'd1, 1'b0}));

        // Set and clear of the same floor on one edge: clear wins
        exp_q.push_back(4);
        send_req(4'd4);
        tick();
        check("t5_moving", 64'({moving, direction}), 64'b11);
        pulse(); pulse();
        floor_sensor = 1'b1; req_valid = 1'b1; req_floor = 4'd4;
        tick();
        floor_sensor = 1'b0; req_valid = 1'b0;
        check("t5_setclr", 64'(pending), 64'd0);
        check("t5_floor", 64'(cur_floor), 64'd4);
        run_car(400);

        // Out-of-range calls, idle sensor pulse, call at current floor
        send_req(4'd15);
        check("t5_range15", 64'(pending), 64'd0);
        send_req(4'd12);
        tick(); tick();
        check("t5_range12", 64'({pending, moving}), 64'd0);
        pulse();
        check("t5_idle_sensor", 64'(cur_floor), 64'd4);
        send_req(4'd4);
        check("t5_here_door", 64'({door_cmd, arrived, pending}), 64'(1) << (NF + 1));
        run_car(100);

        // Overweight holds the door past dwell, then blocks departure
        exp_q.push_back(6);
        send_req(4'd6);
        cnt = 0;
        while (!door_cmd && cnt < 100) begin
            floor_sensor = moving;
            tick();
            floor_sensor = 1'b0;
            cnt++;
        end
        check("t3_door_reached", 64'(door_cmd), 64'd1);
        over_weight = 1'b1;
        repeat (12) tick();
        check("t3_hold", 64'({door_cmd, weight_alert}), 64'b11);
        over_weight = 1'b0;
        tick();
        check("t3_release", 64'({door_cmd, weight_alert, moving}), 64'd0);
        over_weight = 1'b1;
        send_req(4'd2);
        repeat (4) tick();
        check("t3_block", 64'({moving, weight_alert}), 64'd0);
        check("t3_block_pend", 64'(pending), 64'h004);
        exp_q.push_back(2);
        over_weight = 1'b0;
        run_car(400);

        // Door held open: alert on the 180th cycle
        door_open = 1'b1;
        repeat (179) tick();
        check("t4_alert_179", 64'(door_alert), 64'd0);
        tick();
        check("t4_alert_180", 64'(door_alert), 64'd1);
        door_open = 1'b0;
        tick();
        check("t4_alert_clr", 64'(door_alert), 64'd0);

        // Randomized batches collected under overweight, then released in one go
        m_floor = 2;
        m_dir = 1'b0;
        for (int b = 0; b < 25; b++) begin
            mask = '0;
            over_weight = 1'b1;
            for (int k = 0; k < $urandom_range(1, 5); k++) begin
                f = 4'($urandom_range(0, 15));
                if (int'(f) == m_floor) continue;
                send_req(f);
                if (int'(f) < NF) mask[f] = 1'b1;
            end
            tick();
            check("rand_pending", 64'(pending), 64'(mask));
            check("rand_blocked", 64'({moving, weight_alert}), 64'd0);
            over_weight = 1'b0;
            if (mask == '0) continue;
            plan_batch(mask);
            run_car(1500);
            check("rand_end", 64'({cur_floor, direction}), 64'({4'(m_floor), m_dir}));
        end

        // Asynchronous reset while moving at floor 4
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        send_req(4'd9);
        tick();
        repeat (4) pulse();
        check("t6_setup", 64'({cur_floor, moving}), 64'({4'd4, 1'b1}));
        #2 rst_n = 1'b0;
        #1;
        check("t6_async", 64'({cur_floor, pending, moving, direction}), 64'd1);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("t6_discarded", 64'({pending, moving}), 64'd0);

        check("scoreboard_drain", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
